// File: rtl/qsbm_cfg_regs.sv
// qSBM AXI4-Lite configuration/control register file (S00_AXI) feeding the solver core.
// Optional QSBM_CFG_RDBACK_EN: config words 0x0C..0x44 read back their stored value.
module qsbm_cfg_regs #(
  parameter int ADDR_W  = 8,
  parameter int NUM_CFG = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      S00_AXI_AWVALID,
  output logic                      S00_AXI_AWREADY,
  input  logic [ADDR_W-1:0]         S00_AXI_AWADDR,
  input  logic [2:0]                S00_AXI_AWPROT,
  input  logic                      S00_AXI_WVALID,
  output logic                      S00_AXI_WREADY,
  input  logic [31:0]               S00_AXI_WDATA,
  input  logic [3:0]                S00_AXI_WSTRB,
  output logic                      S00_AXI_BVALID,
  input  logic                      S00_AXI_BREADY,
  output logic [1:0]                S00_AXI_BRESP,
  input  logic                      S00_AXI_ARVALID,
  output logic                      S00_AXI_ARREADY,
  input  logic [ADDR_W-1:0]         S00_AXI_ARADDR,
  input  logic [2:0]                S00_AXI_ARPROT,
  output logic                      S00_AXI_RVALID,
  input  logic                      S00_AXI_RREADY,
  output logic [31:0]               S00_AXI_RDATA,
  output logic [1:0]                S00_AXI_RRESP,
  output logic                      core_start,
  output logic                      core_soft_reset,
  input  logic                      core_done,
  input  logic [31:0]               core_iter,
  output logic [32*NUM_CFG-1:0]     cfg_bus
);
  localparam int IW       = ADDR_W - 2;
  localparam int CFG_BASE = 3;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_st_t;
  typedef enum logic {R_IDLE, R_RESP} rd_st_t;

  wr_st_t                    wr_st;
  rd_st_t                    rd_st;
  logic                      aw_held, w_held;
  logic [IW-1:0]             aw_idx;
  logic [31:0]               w_data;
  logic [3:0]                w_strb;
  logic                      busy, done;
  logic [NUM_CFG-1:0][31:0]  cfg_q;

  assign cfg_bus = cfg_q;

  logic unused_ok;
  assign unused_ok = ^{S00_AXI_AWPROT, S00_AXI_ARPROT, S00_AXI_AWADDR[1:0], S00_AXI_ARADDR[1:0]};

  // Write decode; an all-zero strobe is treated as a full-word write
  logic [3:0] be;
  logic       wr_cfg, wr_err;
  always_comb begin
    be     = (w_strb == 4'b0000) ? 4'hF : w_strb;
    wr_cfg = (int'(aw_idx) >= CFG_BASE) && (int'(aw_idx) < CFG_BASE + NUM_CFG);
    wr_err = !(aw_idx == '0 || aw_idx == IW'(1) || wr_cfg) || (wr_cfg && busy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_st           <= W_IDLE;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_idx          <= '0;
      w_data          <= '0;
      w_strb          <= '0;
      S00_AXI_AWREADY <= 1'b0;
      S00_AXI_WREADY  <= 1'b0;
      S00_AXI_BVALID  <= 1'b0;
      S00_AXI_BRESP   <= 2'b00;
      core_start      <= 1'b0;
      core_soft_reset <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_q           <= '0;
    end else begin
      core_start      <= 1'b0;
      core_soft_reset <= 1'b0;
      if (core_done) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      case (wr_st)
        W_IDLE: begin
          if (S00_AXI_AWVALID && S00_AXI_AWREADY) begin
            aw_held         <= 1'b1;
            aw_idx          <= S00_AXI_AWADDR[ADDR_W-1:2];
            S00_AXI_AWREADY <= 1'b0;
          end else if (!aw_held) S00_AXI_AWREADY <= 1'b1;
          if (S00_AXI_WVALID && S00_AXI_WREADY) begin
            w_held         <= 1'b1;
            w_data         <= S00_AXI_WDATA;
            w_strb         <= S00_AXI_WSTRB;
            S00_AXI_WREADY <= 1'b0;
          end else if (!w_held) S00_AXI_WREADY <= 1'b1;
          if (aw_held && w_held) wr_st <= W_COMMIT;
        end
        W_COMMIT: begin
          aw_held        <= 1'b0;
          w_held         <= 1'b0;
          S00_AXI_BVALID <= 1'b1;
          S00_AXI_BRESP  <= wr_err ? 2'b10 : 2'b00;
          wr_st          <= W_RESP;
          if (!wr_err) begin
            if (aw_idx == '0) begin
              // Placed after core_done so a same-cycle start wins
              if (be[0] && w_data[1]) begin
                core_soft_reset <= 1'b1;
                busy            <= 1'b0;
              end else if (be[0] && w_data[0] && !busy) begin
                core_start <= 1'b1;
                busy       <= 1'b1;
                done       <= 1'b0;
              end
            end else if (aw_idx == IW'(1)) begin
              if (be[0] && w_data[1]) done <= 1'b0;
            end else begin
              for (int k = 0; k < NUM_CFG; k++)
                if (int'(aw_idx) == k + CFG_BASE)
                  for (int b = 0; b < 4; b++)
                    if (be[b]) cfg_q[k][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
        end
        default: begin
          if (S00_AXI_BREADY) begin
            S00_AXI_BVALID  <= 1'b0;
            S00_AXI_BRESP   <= 2'b00;
            S00_AXI_AWREADY <= 1'b1;
            S00_AXI_WREADY  <= 1'b1;
            wr_st           <= W_IDLE;
          end
        end
      endcase
    end
  end

  logic [IW-1:0] ar_idx;
  logic [31:0]   rd_data;
  logic          rd_err, rd_cfg;
  assign ar_idx = S00_AXI_ARADDR[ADDR_W-1:2];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    rd_cfg  = (int'(ar_idx) >= CFG_BASE) && (int'(ar_idx) < CFG_BASE + NUM_CFG);
    if (ar_idx == IW'(1)) rd_data = {30'b0, done, busy};
    else if (ar_idx == IW'(2)) rd_data = core_iter;
    else if (rd_cfg) begin
`ifdef QSBM_CFG_RDBACK_EN
      for (int k = 0; k < NUM_CFG; k++)
        if (int'(ar_idx) == k + CFG_BASE) rd_data = cfg_q[k];
`endif
    end else if (ar_idx != '0) rd_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_st           <= R_IDLE;
      S00_AXI_ARREADY <= 1'b0;
      S00_AXI_RVALID  <= 1'b0;
      S00_AXI_RDATA   <= '0;
      S00_AXI_RRESP   <= 2'b00;
    end else begin
      case (rd_st)
        R_IDLE: begin
          if (S00_AXI_ARVALID && S00_AXI_ARREADY) begin
            S00_AXI_ARREADY <= 1'b0;
            S00_AXI_RVALID  <= 1'b1;
            S00_AXI_RDATA   <= rd_data;
            S00_AXI_RRESP   <= rd_err ? 2'b10 : 2'b00;
            rd_st           <= R_RESP;
          end else S00_AXI_ARREADY <= 1'b1;
        end
        default: begin
          if (S00_AXI_RREADY) begin
            S00_AXI_RVALID  <= 1'b0;
            S00_AXI_ARREADY <= 1'b1;
            rd_st           <= R_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qsbm_cfg_regs.sv
// Directed self-checking bench for qsbm_cfg_regs.
module tb_qsbm_cfg_regs;
  localparam int NUM_CFG = 15;

  logic clk = 1'b0;
  logic reset;
  logic S00_AXI_AWVALID, S00_AXI_AWREADY, S00_AXI_WVALID, S00_AXI_WREADY;
  logic S00_AXI_BVALID, S00_AXI_BREADY, S00_AXI_ARVALID, S00_AXI_ARREADY;
  logic S00_AXI_RVALID, S00_AXI_RREADY;
  logic [7:0]  S00_AXI_AWADDR, S00_AXI_ARADDR;
  logic [2:0]  S00_AXI_AWPROT, S00_AXI_ARPROT;
  logic [31:0] S00_AXI_WDATA, S00_AXI_RDATA, core_iter;
  logic [3:0]  S00_AXI_WSTRB;
  logic [1:0]  S00_AXI_BRESP, S00_AXI_RRESP;
  logic        core_start, core_soft_reset, core_done;
  logic [32*NUM_CFG-1:0] cfg_bus;

  logic [NUM_CFG-1:0][31:0] exp_cfg;
  int n_chk = 0, n_fail = 0;
  int start_cnt = 0, soft_cnt = 0;

  qsbm_cfg_regs #(.ADDR_W(8), .NUM_CFG(NUM_CFG)) dut (
    .clk(clk), .reset(reset),
    .S00_AXI_AWVALID(S00_AXI_AWVALID), .S00_AXI_AWREADY(S00_AXI_AWREADY),
    .S00_AXI_AWADDR(S00_AXI_AWADDR), .S00_AXI_AWPROT(S00_AXI_AWPROT),
    .S00_AXI_WVALID(S00_AXI_WVALID), .S00_AXI_WREADY(S00_AXI_WREADY),
    .S00_AXI_WDATA(S00_AXI_WDATA), .S00_AXI_WSTRB(S00_AXI_WSTRB),
    .S00_AXI_BVALID(S00_AXI_BVALID), .S00_AXI_BREADY(S00_AXI_BREADY),
    .S00_AXI_BRESP(S00_AXI_BRESP),
    .S00_AXI_ARVALID(S00_AXI_ARVALID), .S00_AXI_ARREADY(S00_AXI_ARREADY),
    .S00_AXI_ARADDR(S00_AXI_ARADDR), .S00_AXI_ARPROT(S00_AXI_ARPROT),
    .S00_AXI_RVALID(S00_AXI_RVALID), .S00_AXI_RREADY(S00_AXI_RREADY),
    .S00_AXI_RDATA(S00_AXI_RDATA), .S00_AXI_RRESP(S00_AXI_RRESP),
    .core_start(core_start), .core_soft_reset(core_soft_reset),
    .core_done(core_done), .core_iter(core_iter), .cfg_bus(cfg_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_start) start_cnt++;
    if (core_soft_reset) soft_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_ok, w_ok, aw_hs, w_hs;
    int n;
    S00_AXI_AWADDR = addr; S00_AXI_AWVALID = 1'b1;
    S00_AXI_WDATA = data; S00_AXI_WSTRB = strb; S00_AXI_WVALID = 1'b1;
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      aw_hs = S00_AXI_AWVALID && S00_AXI_AWREADY;
      w_hs  = S00_AXI_WVALID && S00_AXI_WREADY;
      tick();
      if (aw_hs) begin aw_ok = 1; S00_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_ok = 1;  S00_AXI_WVALID = 1'b0; end
      n++;
    end
    S00_AXI_AWVALID = 1'b0; S00_AXI_WVALID = 1'b0; S00_AXI_BREADY = 1'b1; n = 0;
    while (!S00_AXI_BVALID && n < 20) begin tick(); n++; end
    resp = S00_AXI_BRESP;
    if (!S00_AXI_BVALID || !(aw_ok && w_ok)) begin
      n_chk++; n_fail++;
      $display("FAIL write_timeout addr=%h", addr);
      resp = 2'bxx;
    end
    tick();
    S00_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ok, hs;
    int n;
    S00_AXI_ARADDR = addr; S00_AXI_ARVALID = 1'b1; ok = 0; n = 0;
    while (!ok && n < 20) begin
      hs = S00_AXI_ARREADY;
      tick();
      if (hs) ok = 1;
      n++;
    end
    S00_AXI_ARVALID = 1'b0; S00_AXI_RREADY = 1'b1; n = 0;
    while (!S00_AXI_RVALID && n < 20) begin tick(); n++; end
    data = S00_AXI_RDATA; resp = S00_AXI_RRESP;
    if (!S00_AXI_RVALID || !ok) begin
      n_chk++; n_fail++;
      $display("FAIL read_timeout addr=%h", addr);
      data = 'x;
    end
    tick();
    S00_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({S00_AXI_AWREADY, S00_AXI_WREADY, S00_AXI_ARREADY, S00_AXI_BVALID, S00_AXI_RVALID,
         core_start, core_soft_reset} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b want=0", {S00_AXI_AWREADY, S00_AXI_WREADY,
        S00_AXI_ARREADY, S00_AXI_BVALID, S00_AXI_RVALID, core_start, core_soft_reset});
    end
    n_chk++;
    if (cfg_bus !== '0 || S00_AXI_RDATA !== 32'h0 || S00_AXI_BRESP !== 2'b00 || S00_AXI_RRESP !== 2'b00) begin
      n_fail++; $display("FAIL reset_data rdata=%h bresp=%b rresp=%b", S00_AXI_RDATA, S00_AXI_BRESP, S00_AXI_RRESP);
    end
    reset = 1'b0;
    tick();
    n_chk++;
    if ({S00_AXI_AWREADY, S00_AXI_WREADY, S00_AXI_ARREADY} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_reset got=%b want=111",
        {S00_AXI_AWREADY, S00_AXI_WREADY, S00_AXI_ARREADY});
    end
  endtask

  task automatic test_same_cycle_aw_w();
    logic [2:0] bv;
    S00_AXI_AWADDR = 8'h0C; S00_AXI_WDATA = 32'd100; S00_AXI_WSTRB = 4'hF;
    S00_AXI_AWVALID = 1'b1; S00_AXI_WVALID = 1'b1;
    tick();
    S00_AXI_AWVALID = 1'b0; S00_AXI_WVALID = 1'b0;
    bv[0] = S00_AXI_BVALID;
    tick(); bv[1] = S00_AXI_BVALID;
    tick(); bv[2] = S00_AXI_BVALID;
    n_chk++;
    if (bv !== 3'b100) begin n_fail++; $display("FAIL bvalid_latency got=%b want=100", bv); end
    n_chk++;
    if (S00_AXI_BRESP !== 2'b00) begin n_fail++; $display("FAIL same_cycle_bresp got=%b want=00", S00_AXI_BRESP); end
    exp_cfg[0] = 32'd100;
    n_chk++;
    if (cfg_bus[31:0] !== 32'd100) begin n_fail++; $display("FAIL word0 got=%0d want=100", cfg_bus[31:0]); end
    S00_AXI_BREADY = 1'b1; tick(); S00_AXI_BREADY = 1'b0;
    n_chk++;
    if (S00_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL bvalid_clear got=%b want=0", S00_AXI_BVALID); end
  endtask

  task automatic test_w_before_aw();
    int n, bad;
    S00_AXI_WDATA = 32'd2000; S00_AXI_WSTRB = 4'hF; S00_AXI_WVALID = 1'b1;
    tick(); S00_AXI_WVALID = 1'b0;
    tick();
    S00_AXI_AWADDR = 8'h10; S00_AXI_AWVALID = 1'b1;
    tick(); S00_AXI_AWVALID = 1'b0;
    n = 0;
    while (!S00_AXI_BVALID && n < 10) begin tick(); n++; end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (S00_AXI_BVALID !== 1'b1 || S00_AXI_AWREADY !== 1'b0 || S00_AXI_WREADY !== 1'b0) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL bvalid_hold bad_cycles=%0d want=0", bad); end
    n_chk++;
    if (S00_AXI_BRESP !== 2'b00) begin n_fail++; $display("FAIL w_first_bresp got=%b want=00", S00_AXI_BRESP); end
    S00_AXI_BREADY = 1'b1; tick(); S00_AXI_BREADY = 1'b0;
    exp_cfg[1] = 32'd2000;
    n_chk++;
    if (cfg_bus[63:32] !== 32'd2000) begin n_fail++; $display("FAIL word1 got=%0d want=2000", cfg_bus[63:32]); end
  endtask

  task automatic test_wstrb();
    logic [1:0] r;
    axi_write(8'h38, 32'h0040_0000, 4'b0000, r);
    exp_cfg[11] = 32'h0040_0000;
    n_chk++;
    if (cfg_bus[11*32 +: 32] !== 32'h0040_0000) begin
      n_fail++; $display("FAIL strb_zero got=%h want=00400000", cfg_bus[11*32 +: 32]);
    end
    axi_write(8'h3C, 32'h0080_0000, 4'hF, r);
    axi_write(8'h3C, 32'hFFFF_FFFF, 4'b0001, r);
    exp_cfg[12] = 32'h0080_00FF;
    n_chk++;
    if (cfg_bus[12*32 +: 32] !== 32'h0080_00FF) begin
      n_fail++; $display("FAIL strb_byte0 got=%h want=008000FF", cfg_bus[12*32 +: 32]);
    end
  endtask

  task automatic test_unmapped();
    logic [1:0] r;
    logic [31:0] d;
    axi_write(8'h48, 32'hDEAD_BEEF, 4'hF, r);
    n_chk++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL unmapped_wr_resp got=%b want=10", r); end
    axi_write(8'h08, 32'h1234, 4'hF, r);
    n_chk++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL iter_wr_resp got=%b want=10", r); end
    n_chk++;
    if (cfg_bus !== exp_cfg) begin n_fail++; $display("FAIL unmapped_no_change got=%h want=%h", cfg_bus, exp_cfg); end
    axi_read(8'h48, d, r);
    n_chk++;
    if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL unmapped_rd got=%h/%b want=0/10", d, r); end
  endtask

  task automatic test_control();
    logic [1:0] r;
    logic [31:0] d;
    int s0, f0;
    s0 = start_cnt; f0 = soft_cnt;
    axi_write(8'h00, 32'h1, 4'hF, r);
    n_chk++;
    if (r !== 2'b00 || start_cnt != s0 + 1) begin
      n_fail++; $display("FAIL start_pulse resp=%b pulses=%0d want=00/1", r, start_cnt - s0);
    end
    axi_read(8'h04, d, r);
    n_chk++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL status_busy got=%h want=1", d); end
    axi_write(8'h30, 32'd5, 4'hF, r);
    n_chk++;
    if (r !== 2'b10 || cfg_bus !== exp_cfg) begin
      n_fail++; $display("FAIL busy_cfg_write resp=%b want=10 dt=%h want=%h", r, cfg_bus[9*32 +: 32], exp_cfg[9]);
    end
    axi_write(8'h00, 32'h1, 4'hF, r);
    n_chk++;
    if (r !== 2'b00 || start_cnt != s0 + 1) begin
      n_fail++; $display("FAIL start_while_busy resp=%b pulses=%0d want=00/1", r, start_cnt - s0);
    end
    core_done = 1'b1; tick(); core_done = 1'b0;
    axi_read(8'h04, d, r);
    n_chk++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL status_done got=%h want=2", d); end
    axi_write(8'h04, 32'h2, 4'hF, r);
    axi_read(8'h04, d, r);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL status_w1c got=%h want=0", d); end
    axi_write(8'h00, 32'h1, 4'hF, r);
    axi_write(8'h00, 32'h2, 4'hF, r);
    axi_read(8'h04, d, r);
    n_chk++;
    if (soft_cnt != f0 + 1 || start_cnt != s0 + 2 || d !== 32'h0 || cfg_bus !== exp_cfg) begin
      n_fail++; $display("FAIL soft_reset soft=%0d start=%0d status=%h want=1/2/0", soft_cnt - f0, start_cnt - s0, d);
    end
  endtask

  task automatic test_readback();
    logic [1:0] r;
    logic [31:0] d, want;
    axi_write(8'h14, 32'd64, 4'hF, r);
    exp_cfg[2] = 32'd64;
`ifdef QSBM_CFG_RDBACK_EN
    want = 32'd64;
`else
    want = 32'd0;
`endif
    axi_read(8'h14, d, r);
    n_chk++;
    if (d !== want || r !== 2'b00) begin n_fail++; $display("FAIL cfg_readback got=%h/%b want=%h/00", d, r, want); end
    core_iter = 32'hCAFE_0123;
    axi_read(8'h08, d, r);
    n_chk++;
    if (d !== 32'hCAFE_0123 || r !== 2'b00) begin n_fail++; $display("FAIL iter_read got=%h/%b want=cafe0123/00", d, r); end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] want;
    int n;
`ifdef QSBM_CFG_RDBACK_EN
    want = 32'd100;
`else
    want = 32'd0;
`endif
    S00_AXI_ARADDR = 8'h0C; S00_AXI_AWADDR = 8'h0C; S00_AXI_WDATA = 32'd777; S00_AXI_WSTRB = 4'hF;
    S00_AXI_ARVALID = 1'b1; S00_AXI_AWVALID = 1'b1; S00_AXI_WVALID = 1'b1;
    tick();
    S00_AXI_ARVALID = 1'b0; S00_AXI_AWVALID = 1'b0; S00_AXI_WVALID = 1'b0;
    n_chk++;
    if (S00_AXI_RVALID !== 1'b1 || S00_AXI_RDATA !== want) begin
      n_fail++; $display("FAIL rw_old_value rvalid=%b got=%h want=%h", S00_AXI_RVALID, S00_AXI_RDATA, want);
    end
    S00_AXI_RREADY = 1'b1; tick(); S00_AXI_RREADY = 1'b0;
    S00_AXI_BREADY = 1'b1; n = 0;
    while (!S00_AXI_BVALID && n < 10) begin tick(); n++; end
    tick(); S00_AXI_BREADY = 1'b0;
    exp_cfg[0] = 32'd777;
    n_chk++;
    if (cfg_bus !== exp_cfg) begin n_fail++; $display("FAIL rw_write_landed got=%h want=309", cfg_bus[31:0]); end
  endtask

  task automatic test_reset_mid_txn();
    int seen, n;
    logic [1:0] r;
    S00_AXI_AWADDR = 8'h10; S00_AXI_AWVALID = 1'b1;
    tick(); S00_AXI_AWVALID = 1'b0;
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    exp_cfg = '0;
    repeat (2) tick();
    n_chk++;
    if (cfg_bus !== exp_cfg) begin n_fail++; $display("FAIL mid_reset_cfg got=%h want=0", cfg_bus); end
    S00_AXI_WDATA = 32'd9; S00_AXI_WSTRB = 4'hF; S00_AXI_WVALID = 1'b1;
    tick(); S00_AXI_WVALID = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (S00_AXI_BVALID) seen++;
      tick();
    end
    n_chk++;
    if (seen != 0) begin n_fail++; $display("FAIL dropped_aw_held bvalid_cycles=%0d want=0", seen); end
    S00_AXI_AWADDR = 8'h10; S00_AXI_AWVALID = 1'b1;
    tick(); S00_AXI_AWVALID = 1'b0;
    S00_AXI_BREADY = 1'b1; n = 0;
    while (!S00_AXI_BVALID && n < 10) begin tick(); n++; end
    r = S00_AXI_BRESP;
    tick(); S00_AXI_BREADY = 1'b0;
    exp_cfg[1] = 32'd9;
    n_chk++;
    if (n >= 10 || r !== 2'b00 || cfg_bus !== exp_cfg) begin
      n_fail++; $display("FAIL post_reset_write bresp=%b word1=%0d want=00/9", r, cfg_bus[63:32]);
    end
  endtask

  initial begin
    reset = 1'b1;
    S00_AXI_AWVALID = 0; S00_AXI_WVALID = 0; S00_AXI_BREADY = 0;
    S00_AXI_ARVALID = 0; S00_AXI_RREADY = 0;
    S00_AXI_AWADDR = 0; S00_AXI_ARADDR = 0; S00_AXI_AWPROT = 0; S00_AXI_ARPROT = 0;
    S00_AXI_WDATA = 0; S00_AXI_WSTRB = 0;
    core_done = 0; core_iter = 0;
    exp_cfg = '0;
    #1;
    test_reset();
    test_same_cycle_aw_w();
    test_w_before_aw();
    test_wstrb();
    test_unmapped();
    test_control();
    test_readback();
    test_rw_same_cycle();
    test_reset_mid_txn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
